vend_payout: RTL and testbench

//  Payout executor downstream of the vending FSM: consumes its one-cycle change/sell

---
 rtl/vend_payout.sv | 192 +++++++++++++++++++
 tb/tb_vend_payout.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_payout.sv
// ---------------------------------------------------------------------------
// vend_payout
// Payout executor behind the vending controller. It accepts a one-cycle
// change/sell result and delivers it. First it drives the goods motor until
// the drop sensor fires. Then it pays change one coin at a time through the
// 5-yuan and 1-yuan hoppers, using the largest coin first. It keeps a fixed
// idle gap between coins and enters a sticky fault state on any sensor timeout.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   change[3:0]        change to pay (yuan); nonzero = command
//   sell[3:0]          goods code 1..3; nonzero = command
//   coin_ack           hopper exit sensor, one pulse per coin
//   motor_done         goods drop sensor
//   clr_err            clears err/overrun, leaves the fault state
//   coin5_out          5-yuan hopper request, held until coin_ack
//   coin1_out          1-yuan hopper request, held until coin_ack
//   motor_en           goods motor drive, held until motor_done
//   motor_sel[1:0]     goods slot being driven
//   busy               command in progress (or fault pending)
//   paid[3:0]          yuan paid out for the current command
//   err                sticky timeout fault
//   overrun            sticky: a command was dropped while not idle
// ---------------------------------------------------------------------------
module vend_payout #(
   parameter int unsigned COIN_TMO  = 255,
   parameter int unsigned MOTOR_TMO = 1023,
   parameter int unsigned GAP_CYC   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] change,
   input  logic [3:0] sell,
   input  logic       coin_ack,
   input  logic       motor_done,
   input  logic       clr_err,
   output logic       coin5_out,
   output logic       coin1_out,
   output logic       motor_en,
   output logic [1:0] motor_sel,
   output logic       busy,
   output logic [3:0] paid,
   output logic       err,
   output logic       overrun
);

   localparam int unsigned MAX_TMO = (COIN_TMO > MOTOR_TMO) ? COIN_TMO : MOTOR_TMO;
   localparam int unsigned CNT_W   = (MAX_TMO < 2) ? 1 : $clog2(MAX_TMO + 1);
   // A zero gap would underflow the terminal count; treat it as one cycle.
   localparam int unsigned GAP_N   = (GAP_CYC == 0) ? 1 : GAP_CYC;

   localparam logic [CNT_W-1:0] COIN_LAST  = CNT_W'(COIN_TMO - 1);
   localparam logic [CNT_W-1:0] MOTOR_LAST = CNT_W'(MOTOR_TMO - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_N - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_VEND = 3'd1,
      S_PAY  = 3'd2,
      S_GAP  = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       rem;

   logic       is_cmd;
   logic       is_vend;
   logic [3:0] denom;

   assign is_cmd  = (change != 4'd0) || (sell != 4'd0);
   // Only goods codes 1..3 ever reach the motor.
   assign is_vend = (sell[3:2] == 2'b00) && (sell[1:0] != 2'b00);
   // The coin being paid is the one whose request line is currently held.
   assign denom   = coin5_out ? 4'd5 : 4'd1;

   // Payout sequencer; every output is a register updated here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         rem       <= 4'd0;
         coin5_out <= 1'b0;
         coin1_out <= 1'b0;
         motor_en  <= 1'b0;
         motor_sel <= 2'd0;
         busy      <= 1'b0;
         paid      <= 4'd0;
         err       <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         // A dropped command in the same cycle as clr_err still flags overrun.
         if (clr_err) overrun <= 1'b0;
         if (is_cmd && (state != S_IDLE)) overrun <= 1'b1;

         case (state)
            S_IDLE: begin
               if (is_cmd) begin
                  rem  <= change;
                  paid <= 4'd0;
                  cnt  <= '0;
                  if (is_vend) begin
                     motor_en  <= 1'b1;
                     motor_sel <= sell[1:0];
                     busy      <= 1'b1;
                     state     <= S_VEND;
                  end else if (change != 4'd0) begin
                     coin5_out <= (change >= 4'd5);
                     coin1_out <= (change <  4'd5);
                     busy      <= 1'b1;
                     state     <= S_PAY;
                  end
               end
            end

            S_VEND: begin
               if (motor_done) begin
                  motor_en <= 1'b0;
                  cnt      <= '0;
                  if (rem != 4'd0) begin
                     coin5_out <= (rem >= 4'd5);
                     coin1_out <= (rem <  4'd5);
                     state     <= S_PAY;
                  end else begin
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end
               end else if (cnt == MOTOR_LAST) begin
                  motor_en <= 1'b0;
                  err      <= 1'b1;
                  cnt      <= '0;
                  state    <= S_ERR;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            // An ack in the timeout cycle is honoured because it is tested first.
            S_PAY: begin
               if (coin_ack) begin
                  coin5_out <= 1'b0;
                  coin1_out <= 1'b0;
                  rem       <= rem - denom;
                  paid      <= paid + denom;
                  cnt       <= '0;
                  state     <= S_GAP;
               end else if (cnt == COIN_LAST) begin
                  coin5_out <= 1'b0;
                  coin1_out <= 1'b0;
                  err       <= 1'b1;
                  cnt       <= '0;
                  state     <= S_ERR;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            S_GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt <= '0;
                  if (rem != 4'd0) begin
                     coin5_out <= (rem >= 4'd5);
                     coin1_out <= (rem <  4'd5);
                     state     <= S_PAY;
                  end else begin
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            // rem/paid are left frozen for diagnosis; clearing abandons the payout.
            S_ERR: begin
               if (clr_err) begin
                  err   <= 1'b0;
                  busy  <= 1'b0;
                  cnt   <= '0;
                  state <= S_IDLE;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vend_payout.sv
// ---------------------------------------------------------------------------
// tb_vend_payout
// Self-checking bench for vend_payout. A responder answers motor and hopper
// requests after a chosen delay. Each command's observed deliveries are
// compared with what the payout rules predict from change and sell alone:
// motor drive, greedy 5/1 coin order, paid total, inter-coin gap and
// first-cycle latency. It also covers both timeouts, ack-at-timeout, dropped
// commands and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_vend_payout;

   localparam int unsigned COIN_TMO  = 255;
   localparam int unsigned MOTOR_TMO = 1023;
   localparam int unsigned GAP_CYC   = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] change;
   logic [3:0] sell;
   logic       coin_ack;
   logic       motor_done;
   logic       clr_err;
   logic       coin5_out;
   logic       coin1_out;
   logic       motor_en;
   logic [1:0] motor_sel;
   logic       busy;
   logic [3:0] paid;
   logic       err;
   logic       overrun;

   logic [11:0] all_out;
   assign all_out = {coin5_out, coin1_out, motor_en, motor_sel, busy, paid, err, overrun};

   vend_payout #(
      .COIN_TMO  (COIN_TMO),
      .MOTOR_TMO (MOTOR_TMO),
      .GAP_CYC   (GAP_CYC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .change     (change),
      .sell       (sell),
      .coin_ack   (coin_ack),
      .motor_done (motor_done),
      .clr_err    (clr_err),
      .coin5_out  (coin5_out),
      .coin1_out  (coin1_out),
      .motor_en   (motor_en),
      .motor_sel  (motor_sel),
      .busy       (busy),
      .paid       (paid),
      .err        (err),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   // Observations from the most recent command.
   int         o_first, o_first_busy, o_motor_cyc, o_sel_bad, o_both;
   int         o_gap_bad, o_seq, o_ncoin, o_last_hi, o_done;
   logic [3:0] o_paid;
   logic       o_busy, o_err, o_overrun;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Issue one command and act as motor/hopper hardware until the block is idle.
   // dly = cycles a request stays high before the sensor answers (0 = never).
   task automatic run_cmd(input int chg, input int sl, input int dly, input int budget,
                          input int inj_at, input int inj_chg);
      int mhi, chi, low_run, c;
      bit prev_coin;
      mhi = 0; chi = 0; low_run = 0; prev_coin = 0;
      o_motor_cyc = 0; o_sel_bad = 0; o_both = 0; o_gap_bad = 0;
      o_seq = 0; o_ncoin = 0; o_last_hi = 0; o_done = 0;
      @(negedge clk);
      change = 4'(chg);
      sell   = 4'(sl);
      @(negedge clk);
      change = 4'd0;
      sell   = 4'd0;
      o_first      = motor_en ? 8 : coin5_out ? 5 : coin1_out ? 1 : 0;
      o_first_busy = int'(busy);
      for (int cyc = 0; cyc < budget; cyc++) begin
         if (cyc > 0) @(negedge clk);
         change = (cyc == inj_at) ? 4'(inj_chg) : 4'd0;
         if (motor_en) begin
            mhi++;
            o_motor_cyc++;
            if (motor_sel !== 2'(sl)) o_sel_bad++;
         end else begin
            mhi = 0;
         end
         motor_done = motor_en && (dly != 0) && (mhi == dly);
         c = coin5_out ? 5 : coin1_out ? 1 : 0;
         if (coin5_out && coin1_out) o_both++;
         if (c != 0) begin
            if (chi == 0) begin
               o_seq = o_seq * 10 + c;
               o_ncoin++;
               if (prev_coin && (low_run != int'(GAP_CYC))) o_gap_bad++;
            end
            chi++;
         end else begin
            if (chi != 0) begin
               prev_coin = 1;
               o_last_hi = chi;
               low_run   = 0;
            end
            chi = 0;
            if (!motor_en) low_run++;
         end
         coin_ack = (c != 0) && (dly != 0) && (chi == dly);
         if (!busy || err) begin
            o_done = 1;
            break;
         end
      end
      motor_done = 1'b0;
      coin_ack   = 1'b0;
      change     = 4'd0;
      o_paid     = paid;
      o_busy     = busy;
      o_err      = err;
      o_overrun  = overrun;
   endtask

   // Reference: motor for codes 1..3, then as many 5s as fit and the rest in 1s.
   task automatic check_cmd(input string tag, input int chg, input int sl, input int dly);
      bit vend, active;
      int exp_seq, exp_first;
      vend    = (sl >= 1) && (sl <= 3);
      active  = vend || (chg != 0);
      exp_seq = 0;
      for (int i = 0; i < chg / 5; i++) exp_seq = exp_seq * 10 + 5;
      for (int i = 0; i < chg % 5; i++) exp_seq = exp_seq * 10 + 1;
      exp_first = vend ? 8 : (chg >= 5) ? 5 : (chg != 0) ? 1 : 0;
      run_cmd(chg, sl, dly, 400, -1, 0);
      check({tag, ".done"},    o_done, 1);
      check({tag, ".first"},   o_first, exp_first);
      check({tag, ".busy1"},   o_first_busy, int'(active));
      check({tag, ".motor"},   o_motor_cyc, vend ? dly : 0);
      check({tag, ".sel"},     o_sel_bad, 0);
      check({tag, ".coins"},   o_seq, exp_seq);
      check({tag, ".both"},    o_both, 0);
      check({tag, ".gap"},     o_gap_bad, 0);
      check({tag, ".paid"},    o_paid, chg);
      check({tag, ".busyend"}, o_busy, 0);
      check({tag, ".err"},     o_err, 0);
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
   endtask

   initial begin
      int chg, sl, dly;
      rst = 1'b1; change = 4'd0; sell = 4'd0;
      coin_ack = 1'b0; motor_done = 1'b0; clr_err = 1'b0;
      @(negedge clk);
      check("reset.outputs", all_out, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset.idle", all_out, 0);

      // Goods only, then goods plus change 8 -> 5,1,1,1.
      check_cmd("sell2", 0, 2, 5);
      check_cmd("sell1_chg8", 8, 1, 3);
      check_cmd("chg4", 4, 0, 2);
      check_cmd("chg15", 15, 0, 1);

      // Coin timeout: request held exactly COIN_TMO cycles, then fault.
      run_cmd(4, 0, 0, COIN_TMO + 20, -1, 0);
      check("ctmo.done",  o_done, 1);
      check("ctmo.hi",    o_last_hi, COIN_TMO);
      check("ctmo.coins", o_seq, 1);
      check("ctmo.err",   o_err, 1);
      check("ctmo.busy",  o_busy, 1);
      check("ctmo.paid",  o_paid, 0);
      pulse_clr();
      check("ctmo.clr_busy", busy, 0);
      check("ctmo.clr_err",  err, 0);

      // Motor timeout.
      run_cmd(0, 3, 0, MOTOR_TMO + 20, -1, 0);
      check("mtmo.done",  o_done, 1);
      check("mtmo.cyc",   o_motor_cyc, MOTOR_TMO);
      check("mtmo.err",   o_err, 1);
      check("mtmo.motor", motor_en, 0);
      pulse_clr();
      check("mtmo.clr_busy", busy, 0);

      // Ack arrives in the very cycle the timeout would fire: coin counts.
      run_cmd(1, 0, COIN_TMO, COIN_TMO + 20, -1, 0);
      check("ackto.done", o_done, 1);
      check("ackto.err",  o_err, 0);
      check("ackto.paid", o_paid, 1);
      check("ackto.hi",   o_last_hi, COIN_TMO);

      // Command during PAY is dropped; payout of 7 continues unchanged.
      run_cmd(7, 0, 3, 400, 2, 3);
      check("ovr.done",    o_done, 1);
      check("ovr.coins",   o_seq, 511);
      check("ovr.paid",    o_paid, 7);
      check("ovr.flag",    o_overrun, 1);
      check("ovr.gap",     o_gap_bad, 0);
      pulse_clr();
      check("ovr.cleared", overrun, 0);

      // Out-of-range goods code with no change: silently dropped.
      check_cmd("sell7", 0, 7, 3);
      check("sell7.ovr", overrun, 0);

      // Randomized commands.
      for (int n = 0; n < 10; n++) begin
         chg = int'($urandom_range(0, 15));
         sl  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 15));
         dly = int'($urandom_range(1, 6));
         if (chg == 0 && sl == 0) chg = 1;
         check_cmd($sformatf("rnd%0d_c%0d_s%0d", n, chg, sl), chg, sl, dly);
      end

      // Asynchronous reset while the 5-yuan hopper is requested.
      @(negedge clk);
      change = 4'd10;
      @(negedge clk);
      change = 4'd0;
      check("rst.coin5_before", coin5_out, 1);
      #2 rst = 1'b1;
      #1 check("rst.async_clear", all_out, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst.idle_after", all_out, 0);
      check_cmd("post_rst", 6, 0, 2);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
